// File: rtl/fa_bist.sv
// Built-in self-test for the lab full adder: sweeps all 8 {a,b,ci} vectors, checks {co,sum}.
// Optional FA_BIST_INJECT_EN adds an 'inject' input that corrupts the expected value.
module fa_bist #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
`ifdef FA_BIST_INJECT_EN
  input  logic       inject,
`endif
  output logic       fa_a,
  output logic       fa_b,
  output logic       fa_ci,
  input  logic       fa_sum,
  input  logic       fa_co,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [2:0] first_fail
);

  localparam logic [7:0] SETTLE_RELOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  state_t     state;
  logic [2:0] vec;
  logic [7:0] settle_cnt;
  logic       seen_fail;
  logic [3:0] checked;

  logic [1:0] expected;
  logic       mismatch;
  logic [3:0] err_next;
  logic [3:0] checked_next;

  assign fa_a  = vec[2];
  assign fa_b  = vec[1];
  assign fa_ci = vec[0];

  always_comb begin
    expected = {1'b0, vec[2]} + {1'b0, vec[1]} + {1'b0, vec[0]};
`ifdef FA_BIST_INJECT_EN
    if (inject) expected[0] = ~expected[0];
`endif
    mismatch     = (expected != {fa_co, fa_sum});
    err_next     = err_count + {3'b000, mismatch};
    checked_next = checked + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      vec        <= '0;
      settle_cnt <= '0;
      seen_fail  <= 1'b0;
      checked    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      first_fail <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            vec        <= '0;
            err_count  <= '0;
            first_fail <= '0;
            seen_fail  <= 1'b0;
            checked    <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= SETTLE_RELOAD;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (settle_cnt == '0) state <= CHECK;
          else                  settle_cnt <= settle_cnt - 8'd1;
        end
        CHECK: begin
          err_count <= err_next;
          checked   <= checked_next;
          if (mismatch && !seen_fail) begin
            first_fail <= vec;
            seen_fail  <= 1'b1;
          end
          // pass uses the post-update counts so the last vector is included
          if (vec == 3'd7) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == 4'd0) && (checked_next == 4'd8);
            state <= DONE;
          end else begin
            vec        <= vec + 3'd1;
            settle_cnt <= SETTLE_RELOAD;
            state      <= SETTLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fa_bist.sv
// Scoreboard bench for fa_bist: stimulus pushes expected sweep results, a monitor checks on done.
module tb_fa_bist;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       inject = 1'b0;
  logic       fa_a, fa_b, fa_ci;
  logic       fa_sum, fa_co;
  logic       busy, done, pass;
  logic [3:0] err_count;
  logic [2:0] first_fail;

  int fa_mode = 0;  // 0 correct, 1 co stuck at 0, 2 sum inverted
  int errors = 0;
  int checks = 0;

  typedef struct {
    int err;
    int first;
    int pass;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  fa_bist #(.SETTLE_CYCLES(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
`ifdef FA_BIST_INJECT_EN
    .inject     (inject),
`endif
    .fa_a       (fa_a),
    .fa_b       (fa_b),
    .fa_ci      (fa_ci),
    .fa_sum     (fa_sum),
    .fa_co      (fa_co),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .first_fail (first_fail)
  );

  // Behavioural FA under test with selectable faults
  always_comb begin
    logic [1:0] s;
    s = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_ci};
    fa_co  = s[1];
    fa_sum = s[0];
    if (fa_mode == 1) fa_co  = 1'b0;
    if (fa_mode == 2) fa_sum = ~s[0];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: tracks busy cycles and stimulus, compares against the scoreboard when done rises
  initial begin
    int  bcnt;
    bit  seq_ok;
    bit  prev_done;
    exp_t e;
    bcnt = 0; seq_ok = 1'b1; prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bcnt = 0; seq_ok = 1'b1; prev_done = 1'b0;
      end else begin
        if (busy) begin
          if ({fa_a, fa_b, fa_ci} != 3'(bcnt / (S + 1))) seq_ok = 1'b0;
          bcnt++;
        end
        if (done && !prev_done) begin
          if (q.size() == 0) begin
            check("unexpected_done", 1, 0);
          end else begin
            e = q.pop_front();
            check("busy_cycles", bcnt, 8 * (S + 1));
            check("err_count", int'(err_count), e.err);
            check("first_fail", int'(first_fail), e.first);
            check("pass", int'(pass), e.pass);
            check("stim_sequence", int'(seq_ok), 1);
          end
          bcnt = 0; seq_ok = 1'b1;
        end
        prev_done = done;
      end
    end
  end

  task automatic run_sweep(input int mode, input int ee, input int ef, input int ep,
                           input bit repulse);
    bit got;
    exp_t e;
    fa_mode = mode;
    e.err = ee; e.first = ef; e.pass = ep;
    q.push_back(e);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;        // edge 0 has passed
    if (repulse) begin
      repeat (9) @(negedge clk);        // now after edge 9
      start = 1'b1;                     // sampled at edge 10
      @(negedge clk) start = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (done) begin got = 1'b1; break; end
      @(negedge clk);
    end
    if (!got) check("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    bit got;
    repeat (3) @(negedge clk);
    check("reset_outputs", int'({fa_a, fa_b, fa_ci, busy, done, pass, err_count, first_fail}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_sweep(0, 0, 0, 1, 1'b0);
    run_sweep(1, 4, 3, 0, 1'b0);
    run_sweep(2, 8, 0, 0, 1'b0);
    run_sweep(0, 0, 0, 1, 1'b1);

    // Reset during vector 4: this sweep never completes, so nothing is pushed
    fa_mode = 0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (busy && {fa_a, fa_b, fa_ci} == 3'd4) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("reach_vector4", int'(got), 1);
    #2 rst_n = 1'b0;
    #1 check("midsweep_reset", int'({fa_a, fa_b, fa_ci, busy, done, pass, err_count, first_fail}), 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    run_sweep(0, 0, 0, 1, 1'b0);

`ifdef FA_BIST_INJECT_EN
    inject = 1'b1;
    run_sweep(0, 8, 0, 0, 1'b0);
    inject = 1'b0;
`endif

    check("scoreboard_drained", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
